// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war match scorer.
//   state_t   : scorer FSM states
//   winner_t  : encoding driven on the winner output
//   SEG_BLANK : all segments off (active-low)
//   SEG_DIGIT : active-low {g,f,e,d,c,b,a} patterns for digits 0..9
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'b00,
    HOLD       = 2'b01,
    MATCH_OVER = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10
  } winner_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/seg7_digit.sv
// Combinational hex-digit to seven-segment decoder.
//   value : 4-bit value to display
//   seg   : active-low segments {g,f,e,d,c,b,a}; blank for values above 9
module seg7_digit
  import tow_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (value <= 4'd9) seg = SEG_DIGIT[value];
  end

endmodule

// File: rtl/match_scorer.sv
// Tug-of-war match scorer: detects round wins, keeps per-player scores,
// freezes the playfield between rounds and declares the match winner.
//   clk, reset (async active-low)
//   Llight, Rlight : edge LEDs of the playfield
//   L, R           : player buttons (synchronised levels)
//   new_match      : synchronous restart, overrides everything but reset
//   hex_l, hex_r   : active-low score digits
//   freeze         : playfield ignores buttons while high
//   round_reset    : one-cycle recentre pulse
//   game_over      : match decided
//   winner         : 00 none, 01 left, 10 right
module match_scorer
  import tow_pkg::*;
#(
  parameter int WIN_ROUNDS  = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Llight,
  input  logic       Rlight,
  input  logic       L,
  input  logic       R,
  input  logic       new_match,
  output logic [6:0] hex_l,
  output logic [6:0] hex_r,
  output logic       freeze,
  output logic       round_reset,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int SCORE_W = $clog2(WIN_ROUNDS + 1);
  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WIN_ROUNDS);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t             state;
  winner_t            winner_q;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic [7:0]         hold_cnt;

  logic               lwin;
  logic               rwin;
  logic [SCORE_W-1:0] l_inc;
  logic [SCORE_W-1:0] r_inc;
  logic [SCORE_W-1:0] won_score;

  assign lwin = Llight & ~Rlight & L & ~R;
  assign rwin = Rlight & ~Llight & R & ~L;

  // Saturating increments; the winning player's new score decides the next state.
  assign l_inc     = (score_l == WIN_SCORE) ? score_l : score_l + 1'b1;
  assign r_inc     = (score_r == WIN_SCORE) ? score_r : score_r + 1'b1;
  assign won_score = lwin ? l_inc : r_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= PLAY;
      winner_q    <= WIN_NONE;
      score_l     <= '0;
      score_r     <= '0;
      hold_cnt    <= '0;
      freeze      <= 1'b0;
      round_reset <= 1'b0;
      game_over   <= 1'b0;
    end else if (new_match) begin
      state       <= PLAY;
      winner_q    <= WIN_NONE;
      score_l     <= '0;
      score_r     <= '0;
      hold_cnt    <= '0;
      freeze      <= 1'b0;
      round_reset <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          round_reset <= 1'b0;
          // The recentre cycle still shows the old light position, so skip it.
          if (!round_reset && (lwin || rwin)) begin
            if (lwin) score_l <= l_inc;
            else      score_r <= r_inc;
            freeze <= 1'b1;
            if (won_score == WIN_SCORE) begin
              state     <= MATCH_OVER;
              game_over <= 1'b1;
              winner_q  <= lwin ? WIN_LEFT : WIN_RIGHT;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == 8'd0) begin
            state       <= PLAY;
            freeze      <= 1'b0;
            round_reset <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        MATCH_OVER: begin
          round_reset <= 1'b0;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

  assign winner = winner_q;

  seg7_digit u_seg_l (
    .value (4'(score_l)),
    .seg   (hex_l)
  );

  seg7_digit u_seg_r (
    .value (4'(score_r)),
    .seg   (hex_r)
  );

endmodule

// File: tb/tb_match_scorer.sv
// Randomised and directed bench for match_scorer against a round-level
// reference model (scores, remaining freeze cycles, pending recentre).
module tb_match_scorer;

  localparam int WIN_ROUNDS  = 3;
  localparam int HOLD_CYCLES = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       Llight, Rlight, L, R, new_match;
  logic [6:0] hex_l, hex_r;
  logic       freeze, round_reset, game_over;
  logic [1:0] winner;

  match_scorer #(
    .WIN_ROUNDS  (WIN_ROUNDS),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Llight      (Llight),
    .Rlight      (Rlight),
    .L           (L),
    .R           (R),
    .new_match   (new_match),
    .hex_l       (hex_l),
    .hex_r       (hex_r),
    .freeze      (freeze),
    .round_reset (round_reset),
    .game_over   (game_over),
    .winner      (winner)
  );

  // Independent digit table: 0..9 then blanks.
  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
    7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f
  };

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  int m_sc [2];
  int m_freeze_left;
  bit m_over;
  bit m_rr;
  int m_winner;

  task automatic model_reset();
    m_sc[0] = 0; m_sc[1] = 0;
    m_freeze_left = 0;
    m_over = 0; m_rr = 0; m_winner = 0;
  endtask

  task automatic model_step(input bit ll, input bit rl, input bit l, input bit r, input bit nm);
    bit lw, rw, was_rr;
    int idx;
    lw = ll && !rl && l && !r;
    rw = rl && !ll && r && !l;
    if (nm) begin
      model_reset();
      m_rr = 1;
    end else if (m_over) begin
      m_rr = 0;
    end else if (m_freeze_left > 0) begin
      m_freeze_left--;
      m_rr = (m_freeze_left == 0);
    end else begin
      was_rr = m_rr;
      m_rr = 0;
      if (!was_rr && (lw || rw)) begin
        idx = lw ? 0 : 1;
        if (m_sc[idx] < WIN_ROUNDS) m_sc[idx]++;
        if (m_sc[idx] == WIN_ROUNDS) begin
          m_over = 1;
          m_winner = lw ? 1 : 2;
        end else begin
          m_freeze_left = HOLD_CYCLES;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".hex_l"}, hex_l, seg_ref[m_sc[0]]);
    check({tag, ".hex_r"}, hex_r, seg_ref[m_sc[1]]);
    check({tag, ".freeze"}, freeze, m_over || (m_freeze_left > 0));
    check({tag, ".round_reset"}, round_reset, m_rr);
    check({tag, ".game_over"}, game_over, m_over);
    check({tag, ".winner"}, winner, m_winner[1:0]);
  endtask

  // driver: inputs change after the falling edge, model steps on rising edge,
  // outputs compared 1 time unit later.
  task automatic drive_cycle(input string tag, input bit ll, input bit rl,
                             input bit l, input bit r, input bit nm);
    @(negedge clk);
    Llight = ll; Rlight = rl; L = l; R = r; new_match = nm;
    @(posedge clk);
    model_step(ll, rl, l, r, nm);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) drive_cycle(tag, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    Llight = 0; Rlight = 0; L = 0; R = 0; new_match = 0;
    model_reset();
    #12;
    check_all("reset");
    check("reset.hex_l_zero", hex_l, 7'b1000000);
    @(negedge clk);
    reset = 1'b1;
    idle("post_reset", 2);

    // single left win: '1', four frozen cycles, then one recentre pulse
    drive_cycle("lwin", 1, 0, 1, 0, 0);
    check("lwin.hex_l_one", hex_l, 7'b1111001);
    check("lwin.freeze_rise", freeze, 1'b1);
    idle("lwin_hold", 6);

    // held win condition: one increment per round only
    for (int i = 0; i < 12; i++) drive_cycle("lhold", 1, 0, 1, 0, 0);
    idle("lhold_rel", 6);

    // restart, then right takes three rounds
    drive_cycle("nm1", 0, 0, 0, 0, 1);
    check("nm1.round_reset", round_reset, 1'b1);
    for (int k = 0; k < 3; k++) begin
      idle("r_gap", 2);
      drive_cycle("rwin", 0, 1, 0, 1, 0);
      idle("r_hold", 6);
    end
    check("r3.hex_r_three", hex_r, 7'b0110000);
    check("r3.winner_right", winner, 2'b10);
    check("r3.game_over", game_over, 1'b1);
    for (int i = 0; i < 4; i++) drive_cycle("over_l", 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive_cycle("over_r", 0, 1, 0, 1, 0);

    // restart from MATCH_OVER, then restart coincident with a left win
    drive_cycle("nm2", 0, 0, 0, 0, 1);
    check("nm2.hex_r_zero", hex_r, 7'b1000000);
    idle("nm2_gap", 2);
    drive_cycle("nm_lwin", 1, 0, 1, 0, 1);
    check("nm_lwin.hex_l_zero", hex_l, 7'b1000000);
    idle("nm_lwin_gap", 2);

    // async reset in HOLD with counter at 2
    drive_cycle("pre_rst_win", 1, 0, 1, 0, 0);
    drive_cycle("pre_rst_hold", 0, 0, 0, 0, 0);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle("after_reset", 3);

    // random traffic: lights mostly one-sided, rare restarts
    for (int i = 0; i < 3000; i++) begin
      bit ll, rl, l, r, nm;
      ll = ($urandom_range(0, 3) == 0);
      rl = ($urandom_range(0, 3) == 0);
      l  = ($urandom_range(0, 1) == 0);
      r  = ($urandom_range(0, 1) == 0);
      nm = ($urandom_range(0, 63) == 0);
      drive_cycle("rand", ll, rl, l, r, nm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/match_scorer.md
Name: match_scorer

Overview:
- Parametrised successor to the single-round victory detector for the tug-of-war game.
- Detects round wins from the playfield edge lights and player buttons, and keeps a per-player round score.
- Freezes the playfield for a hold period after each round, then pulses a playfield reset.
- Declares a match winner once a player reaches WIN_ROUNDS, and drives two seven-segment score digits.

Parameters:
- WIN_ROUNDS, 3, rounds needed to win the match; legal range 1..9 so each score fits one hex digit.
- HOLD_CYCLES, 4, cycles the playfield stays frozen after a non-final round win; legal range 1..255.
- SCORE_W, $clog2(WIN_ROUNDS+1), width of each score counter; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately.
- Llight  input  1  leftmost playfield LED lit.
- Rlight  input  1  rightmost playfield LED lit.
- L  input  1  left player button, level, already synchronised.
- R  input  1  right player button, level, already synchronised.
- new_match  input  1  synchronous match restart, sampled every cycle.
- hex_l  output  7  left score digit, active-low segments {g,f,e,d,c,b,a}.
- hex_r  output  7  right score digit, same encoding.
- freeze  output  1  playfield must ignore buttons while high.
- round_reset  output  1  one-cycle pulse telling the playfield to recentre.
- game_over  output  1  match decided.
- winner  output  2  2'b00 none, 2'b01 left, 2'b10 right.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=PLAY, both scores=0, hold counter=0.
  - freeze=0, round_reset=0, game_over=0, winner=2'b00.
  - hex_l=hex_r=7'b1000000 (digit '0').
- All outputs are registered or decoded only from registers; no input-to-output combinational path.
- Round-win conditions:
  - lwin = Llight & ~Rlight & L & ~R
  - rwin = Rlight & ~Llight & R & ~L
  - The two are mutually exclusive by construction. Both low means no event.
- State PLAY:
  - Wins are evaluated only when round_reset is low, i.e. never in the first PLAY cycle after a round reset.
  - On lwin or rwin: the winner's score increments.
  - If the new score equals WIN_ROUNDS: go to MATCH_OVER, set winner.
  - Otherwise: go to HOLD and load the hold counter with HOLD_CYCLES-1.
  - freeze rises in the cycle after the winning sample.
- State HOLD:
  - freeze=1; all L, R and light inputs are ignored.
  - Counter decrements each cycle.
  - When the counter is 0: go to PLAY and assert round_reset in that first PLAY cycle (exactly one cycle high).
  - Total freeze duration is exactly HOLD_CYCLES cycles.
- State MATCH_OVER:
  - freeze=1, game_over=1, winner held, scores held.
  - round_reset stays 0; state stays until new_match.
- new_match=1 in any state, highest priority over win detection:
  - Next cycle: scores=0, state=PLAY, winner=00, game_over=0, freeze=0, round_reset=1 for one cycle.
  - A win present in the same cycle as new_match is discarded.
- Scores saturate at WIN_ROUNDS; they never wrap.
- Digit decode: standard 0..9 active-low patterns; any value outside 0..9 blanks the digit (7'b1111111).
- reset asserted mid-HOLD or mid-MATCH_OVER: immediate return to reset values; no round_reset pulse.

Decomposition:
- Package tow_pkg:
  - state_t enum {PLAY, HOLD, MATCH_OVER}, logic [1:0].
  - winner_t encodings.
  - SEG_BLANK and SEG_DIGIT[0:9] constants.
- Sub-module seg7_digit: 4-bit value to 7-bit active-low segments, purely combinational; instantiated twice.

Test Plan:
- Reset release with all inputs 0 -> state PLAY, hex_l=hex_r=7'b1000000, freeze=0, game_over=0, winner=00.
- Llight=1, L=1 for one cycle (WIN_ROUNDS=3, HOLD_CYCLES=4) -> hex_l=7'b1111001 ('1'), freeze high for exactly 4 cycles, then round_reset high for 1 cycle, freeze=0.
- Llight=1, L=1 held continuously -> exactly one increment per round; no win counted during the HOLD or round_reset cycles.
- Right player wins 3 rounds -> hex_r=7'b0110000 ('3'), game_over=1, winner=10, freeze=1, no round_reset after the third win. Further lwin/rwin stimulus -> no change.
- new_match pulse in MATCH_OVER -> next cycle scores 0/0, game_over=0, winner=00, round_reset=1 for one cycle. new_match coincident with lwin in PLAY -> score stays 0.
- reset driven low mid-HOLD (counter=2) -> outputs at reset values before the next clk edge; after release, PLAY with scores 0/0.
